// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared definitions for the SPI responder.
//             - Default byte width and default underrun reply byte.
//             - FSM state encoding (IDLE / LOAD / SHIFT).
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int         SPI_DATA_W    = 8;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Brings one asynchronous pin into the clk domain through a
//             SYNC_STAGES flop chain, then one edge-detect flop. An edge on
//             the pin shows up as a one-clk rise/fall pulse that the next
//             clk edge acts on (SYNC_STAGES+1 clk pin-to-action latency).
//  Ports    : clk     - system clock
//             rst     - asynchronous active-high reset
//             din_i   - asynchronous input pin
//             level_o - synchronised level
//             rise_o  - one-clk pulse on a synchronised 0->1 transition
//             fall_o  - one-clk pulse on a synchronised 1->0 transition
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the pin's idle level so that leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_dual_resp.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_dual_resp
//  Purpose  : SPI mode-0 responder, MSB first, one instance per ss_n line.
//             sck/ss_n/mosi are oversampled in the clk domain. Replies come
//             from a one-entry holding register filled by a valid/ready
//             handshake; received bytes appear on rx_data with rx_valid.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             sck, ss_n, mosi   - SPI pins from the master (asynchronous)
//             miso, miso_oe     - reply data and its drive enable
//             tx_data/valid/ready - reply byte handshake
//             rx_data, rx_valid - received byte and one-clk strobe
//             busy              - frame in progress
//             tx_underrun       - byte started with empty holding register
//             frame_abort       - ss_n deasserted in the middle of a byte
//  Options  : SPI_SLAVE_ECHO_EN - when defined, an underrun replies with the
//             last received byte instead of IDLE_BYTE.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_dual_resp
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(SPI_IDLE_BYTE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din_i(sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din_i(ss_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign w_unused = &{1'b0, sck_lvl, ss_lvl, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              load_pend_q, load_pend_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;

  logic              do_load;
  logic              byte_last;
  logic [DATA_W-1:0] load_byte;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] fallback;

`ifdef SPI_SLAVE_ECHO_EN
  assign fallback = rx_data_q;
`else
  assign fallback = IDLE_BYTE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_pend_d = load_pend_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    do_load     = 1'b0;
    load_byte   = '0;
    rx_next     = {rx_shift_q[DATA_W-2:0], mosi_lvl};
    byte_last   = sck_rise && (bitcnt_q == LAST_BIT);

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end else begin
          do_load     = 1'b1;
          miso_oe_d   = 1'b1;
          bitcnt_d    = '0;
          load_pend_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          rx_shift_d = rx_next;
          if (byte_last) begin
            rx_data_d   = rx_next;
            rx_valid_d  = 1'b1;
            bitcnt_d    = '0;
            // Next byte is loaded on the coming sck fall.
            load_pend_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
        // ss_rise wins over a coincident sck fall, so a master that drops
        // sck and ss_n together does not trigger a spurious reload.
        if (ss_rise) begin
          state_d     = ST_IDLE;
          miso_oe_d   = 1'b0;
          miso_d      = 1'b0;
          load_pend_d = 1'b0;
          bitcnt_d    = '0;
          abort_d     = sck_rise ? !byte_last : (bitcnt_q != '0);
        end else if (sck_fall) begin
          if (load_pend_q) begin
            do_load     = 1'b1;
            load_pend_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Holding register: a load drains it first; a handshake into an empty
    // register during a load bypasses straight into the shifter.
    if (do_load) begin
      if (hold_full_q) begin
        load_byte   = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_valid) begin
        load_byte = tx_data;
      end else begin
        load_byte  = fallback;
        underrun_d = 1'b1;
      end
      tx_shift_d = load_byte;
      miso_d     = load_byte[DATA_W-1];
    end else if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule
`default_nettype wire
